// File: rtl/jtaglet_pkg.sv
// jtaglet_pkg: shared types and constants for the jtaglet JTAG TAP.
//   tap_state_e  - the sixteen TAP controller states
//   tap_ctrl_t   - decoded capture/shift/update strobes for the DR and IR paths
//   dr_sel_e     - which data register the current instruction selects
//   INSTR_*      - instruction codes; the top widens them to IR_LEN bits
//   tap_next()   - TAP state transition function
//   tap_decode() - strobe decode of a TAP state
package jtaglet_pkg;

  localparam int unsigned USERDATA_W = 32;
  localparam int unsigned USEROP_W   = 8;
  localparam int unsigned IDCODE_W   = 32;

  localparam int unsigned INSTR_IDCODE   = 1;
  localparam int unsigned INSTR_USERDATA = 2;
  localparam int unsigned INSTR_USEROP   = 3;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_RTI,
    ST_SEL_DR,
    ST_CAP_DR,
    ST_SHIFT_DR,
    ST_EXIT1_DR,
    ST_PAUSE_DR,
    ST_EXIT2_DR,
    ST_UPD_DR,
    ST_SEL_IR,
    ST_CAP_IR,
    ST_SHIFT_IR,
    ST_EXIT1_IR,
    ST_PAUSE_IR,
    ST_EXIT2_IR,
    ST_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USERDATA,
    DR_USEROP
  } dr_sel_e;

  typedef struct packed {
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
  } tap_ctrl_t;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      ST_TLR:      return tms ? ST_TLR      : ST_RTI;
      ST_RTI:      return tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   return tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   return tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: return tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: return tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: return tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: return tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   return tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   return tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   return tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: return tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: return tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: return tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: return tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   return tms ? ST_SEL_DR   : ST_RTI;
      default:     return ST_TLR;
    endcase
  endfunction

  function automatic tap_ctrl_t tap_decode(input tap_state_e s);
    tap_ctrl_t c;
    c            = '0;
    c.capture_dr = (s == ST_CAP_DR);
    c.shift_dr   = (s == ST_SHIFT_DR);
    c.update_dr  = (s == ST_UPD_DR);
    c.capture_ir = (s == ST_CAP_IR);
    c.shift_ir   = (s == ST_SHIFT_IR);
    c.update_ir  = (s == ST_UPD_IR);
    return c;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller.
//   tck   in  JTAG clock
//   trst  in  asynchronous active-low reset, forces Test-Logic-Reset
//   tms   in  mode select, sampled on rising tck
//   state out current TAP state
//   ctrl  out strobes for the current state; an action flagged here is
//             performed by the datapath on the rising tck that leaves the state
module jtag_tap_fsm
  import jtaglet_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state,
  output tap_ctrl_t  ctrl
);

  tap_state_e state_q, state_d;
  tap_ctrl_t  ctrl_q, ctrl_d;

  // NOTE: every signal driven in an always_comb gets a value on every path
  // (here unconditionally) so no latch can be inferred.
  always_comb begin
    state_d = tap_next(state_q, tms);
    // Strobes are decoded from the next state so they come out of a flop
    // yet still line up with state_q.
    ctrl_d  = tap_decode(state_d);
  end

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q <= ST_TLR;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign state = state_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/jtaglet_tap.sv
// jtaglet_tap: JTAG TAP with BYPASS, IDCODE, USERDATA and USEROP registers.
//   tck           in   JTAG clock, the only clock
//   trst          in   asynchronous active-low reset
//   tms, tdi      in   sampled on rising tck
//   tdo           out  registered on falling tck; 0 outside Shift-IR/Shift-DR
//   userData_in   in   word captured into USERDATA at Capture-DR
//   userData_out  out  last USERDATA word written at Update-DR
//   userOp        out  last USEROP byte written at Update-DR
//   userOp_ready  out  one-tck pulse after userOp is written
// IR_LEN must be in 2..8.
module jtaglet_tap
  import jtaglet_pkg::*;
#(
  parameter int unsigned  IR_LEN     = 4,
  parameter logic [3:0]   ID_PARTVER = 4'h0,
  parameter logic [15:0]  ID_PARTNUM = 16'h0000,
  parameter logic [10:0]  ID_MANF    = 11'h000
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic [USERDATA_W-1:0] userData_in,
  output logic [USERDATA_W-1:0] userData_out,
  output logic [USEROP_W-1:0]   userOp,
  output logic                  userOp_ready
);

  localparam logic [IR_LEN-1:0]   IR_IDCODE   = IR_LEN'(INSTR_IDCODE);
  localparam logic [IR_LEN-1:0]   IR_USERDATA = IR_LEN'(INSTR_USERDATA);
  localparam logic [IR_LEN-1:0]   IR_USEROP   = IR_LEN'(INSTR_USEROP);
  localparam logic [IR_LEN-1:0]   IR_BYPASS   = {IR_LEN{1'b1}};
  localparam logic [IR_LEN-1:0]   IR_CAPTURE  = IR_LEN'(1);
  localparam logic [IDCODE_W-1:0] IDCODE_VAL  = {ID_PARTVER, ID_PARTNUM, ID_MANF, 1'b1};

  tap_state_e state;
  tap_ctrl_t  ctrl;

  jtag_tap_fsm u_fsm (
    .tck   (tck),
    .trst  (trst),
    .tms   (tms),
    .state (state),
    .ctrl  (ctrl)
  );

  logic [IR_LEN-1:0]     ir_q, ir_d;
  logic [IR_LEN-1:0]     ir_sr_q, ir_sr_d;
  // One shift register serves every DR; each instruction sets where tdi enters.
  logic [USERDATA_W-1:0] dr_sr_q, dr_sr_d;
  logic [USERDATA_W-1:0] user_data_q, user_data_d;
  logic [USEROP_W-1:0]   user_op_q, user_op_d;
  logic                  user_op_ready_q, user_op_ready_d;
  logic                  tdo_q, tdo_d;
  dr_sel_e               dr_sel;

  // All-ones is checked first so that with IR_LEN=2 code 3 still means BYPASS.
  always_comb begin
    if (ir_q == IR_BYPASS)        dr_sel = DR_BYPASS;
    else if (ir_q == IR_IDCODE)   dr_sel = DR_IDCODE;
    else if (ir_q == IR_USERDATA) dr_sel = DR_USERDATA;
    else if (ir_q == IR_USEROP)   dr_sel = DR_USEROP;
    else                          dr_sel = DR_BYPASS;
  end

  always_comb begin
    ir_d    = ir_q;
    ir_sr_d = ir_sr_q;
    if (state == ST_TLR)    ir_d    = IR_IDCODE;
    else if (ctrl.update_ir) ir_d   = ir_sr_q;
    if (ctrl.capture_ir)    ir_sr_d = IR_CAPTURE;
    else if (ctrl.shift_ir) ir_sr_d = {tdi, ir_sr_q[IR_LEN-1:1]};
  end

  always_comb begin
    dr_sr_d = dr_sr_q;
    if (ctrl.capture_dr) begin
      case (dr_sel)
        DR_IDCODE:   dr_sr_d = IDCODE_VAL;
        DR_USERDATA: dr_sr_d = userData_in;
        default:     dr_sr_d = '0;
      endcase
    end else if (ctrl.shift_dr) begin
      case (dr_sel)
        DR_BYPASS: dr_sr_d = {{(USERDATA_W-1){1'b0}}, tdi};
        DR_USEROP: dr_sr_d = {{(USERDATA_W-USEROP_W){1'b0}}, tdi, dr_sr_q[USEROP_W-1:1]};
        default:   dr_sr_d = {tdi, dr_sr_q[USERDATA_W-1:1]};
      endcase
    end
  end

  always_comb begin
    user_data_d     = user_data_q;
    user_op_d       = user_op_q;
    user_op_ready_d = 1'b0;
    if (ctrl.update_dr && dr_sel == DR_USERDATA) user_data_d = dr_sr_q;
    if (ctrl.update_dr && dr_sel == DR_USEROP) begin
      user_op_d       = dr_sr_q[USEROP_W-1:0];
      user_op_ready_d = 1'b1;
    end
  end

  always_comb begin
    tdo_d = 1'b0;
    if (ctrl.shift_ir)      tdo_d = ir_sr_q[0];
    else if (ctrl.shift_dr) tdo_d = dr_sr_q[0];
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_q            <= IR_IDCODE;
      ir_sr_q         <= '0;
      dr_sr_q         <= '0;
      user_data_q     <= '0;
      user_op_q       <= '0;
      user_op_ready_q <= 1'b0;
    end else begin
      ir_q            <= ir_d;
      ir_sr_q         <= ir_sr_d;
      dr_sr_q         <= dr_sr_d;
      user_data_q     <= user_data_d;
      user_op_q       <= user_op_d;
      user_op_ready_q <= user_op_ready_d;
    end
  end

  // tdo changes on the falling edge so the next device in the chain has half
  // a period of setup before it samples on rising tck.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) tdo_q <= 1'b0;
    else       tdo_q <= tdo_d;
  end

  assign tdo          = tdo_q;
  assign userData_out = user_data_q;
  assign userOp       = user_op_q;
  assign userOp_ready = user_op_ready_q;

endmodule

// File: tb/tb_jtaglet_tap.sv
// Directed bench for jtaglet_tap: a single device plus a three-device chain.
// Inputs are driven just after the falling edge; tdo and outputs are read there.
module tb_jtaglet_tap;

  logic        tck = 1'b0;
  logic        trst = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        use_chain = 1'b0;
  logic [31:0] user_data_in = 32'h0;

  int errors = 0;
  int checks = 0;

  always #5 tck = ~tck;

  // The idle target is held in Test-Logic-Reset by a constant tms=1.
  wire tms_s = use_chain ? 1'b1 : tms;
  wire tms_c = use_chain ? tms : 1'b1;

  wire        tdo_s, ready_s;
  wire [31:0] udo_s;
  wire [7:0]  op_s;

  jtaglet_tap #(.IR_LEN(4), .ID_PARTVER(4'h5), .ID_PARTNUM(16'h3817), .ID_MANF(11'h482)) dut (
    .tck(tck), .trst(trst), .tms(tms_s), .tdi(tdi), .tdo(tdo_s),
    .userData_in(user_data_in), .userData_out(udo_s), .userOp(op_s), .userOp_ready(ready_s)
  );

  wire        tdo_a, tdo_b, tdo_c;
  wire [31:0] udo_a, udo_b, udo_c;
  wire [7:0]  op_a, op_b, op_c;
  wire        rdy_a, rdy_b, rdy_c;

  jtaglet_tap #(.IR_LEN(4), .ID_PARTVER(4'h5), .ID_PARTNUM(16'h3817), .ID_MANF(11'h482)) u_a (
    .tck(tck), .trst(trst), .tms(tms_c), .tdi(tdi), .tdo(tdo_a),
    .userData_in(32'h0), .userData_out(udo_a), .userOp(op_a), .userOp_ready(rdy_a)
  );
  jtaglet_tap #(.IR_LEN(5), .ID_PARTVER(4'hc), .ID_PARTNUM(16'h8215), .ID_MANF(11'h619)) u_b (
    .tck(tck), .trst(trst), .tms(tms_c), .tdi(tdo_a), .tdo(tdo_b),
    .userData_in(32'h0), .userData_out(udo_b), .userOp(op_b), .userOp_ready(rdy_b)
  );
  jtaglet_tap #(.IR_LEN(4), .ID_PARTVER(4'ha), .ID_PARTNUM(16'h9243), .ID_MANF(11'h267)) u_c (
    .tck(tck), .trst(trst), .tms(tms_c), .tdi(tdo_b), .tdo(tdo_c),
    .userData_in(32'h0), .userData_out(udo_c), .userOp(op_c), .userOp_ready(rdy_c)
  );

  wire tdo_obs = use_chain ? tdo_c : tdo_s;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One tck: read tdo, then present tms/tdi for the coming rising edge.
  task automatic bit_step(input logic m, input logic d, output logic o);
    @(negedge tck);
    #1;
    o   = tdo_obs;
    tms = m;
    tdi = d;
  endtask

  task automatic move(input logic m);
    logic o;
    bit_step(m, 1'b0, o);
  endtask

  task automatic settle();
    @(negedge tck);
    #1;
  endtask

  task automatic shift(input int n, input logic [95:0] din, input logic last_exit,
                       output logic [95:0] dout);
    logic o;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      bit_step(last_exit && (i == n - 1), din[i], o);
      dout[i] = o;
    end
  endtask

  task automatic rti_to_shift_dr();
    move(1'b1); move(1'b0); move(1'b0);
  endtask

  task automatic rti_to_shift_ir();
    move(1'b1); move(1'b1); move(1'b0); move(1'b0);
  endtask

  task automatic exit1_to_rti();
    move(1'b1); move(1'b0);
  endtask

  task automatic load_ir_single(input logic [3:0] code);
    logic [95:0] d;
    rti_to_shift_ir();
    shift(4, {92'h0, code}, 1'b1, d);
    check("ir_capture", d[3:0], 4'b0001);
    exit1_to_rti();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [95:0] d;
    logic        o;

    // Reset state
    #23;
    check("rst_tdo", tdo_s, 1'b0);
    check("rst_udo", udo_s, 32'h0);
    check("rst_op", op_s, 8'h0);
    check("rst_ready", ready_s, 1'b0);
    @(negedge tck);
    #1;
    trst = 1'b1;

    // Chain: IDCODE after reset, nearest-to-tdo device first
    use_chain = 1'b1;
    move(1'b0);
    rti_to_shift_dr();
    shift(96, 96'h0, 1'b1, d);
    check("chain_id_c", d[31:0], 32'hA92434CF);
    check("chain_id_b", d[63:32], 32'hC8215C33);
    check("chain_id_a", d[95:64], 32'h53817905);
    exit1_to_rti();

    // Chain IR capture (4+5+4) and load all-ones
    rti_to_shift_ir();
    shift(13, 96'h1FFF, 1'b1, d);
    check("chain_ir_capture", d[12:0], 13'h0211);
    exit1_to_rti();

    // Three bypass bits give three clocks of delay
    rti_to_shift_dr();
    shift(8, 96'h01, 1'b1, d);
    check("chain_bypass_1", d[7:0], 8'h08);
    exit1_to_rti();
    rti_to_shift_dr();
    shift(8, 96'h2D, 1'b1, d);
    check("chain_bypass_2d", d[7:0], 8'h68);
    exit1_to_rti();

    // Single device: IDCODE with no IR load
    use_chain = 1'b0;
    user_data_in = 32'hE6712945;
    move(1'b0);
    rti_to_shift_dr();
    shift(32, 96'h0, 1'b1, d);
    check("single_idcode", d[31:0], 32'h53817905);
    exit1_to_rti();

    // USERDATA capture, update, recapture
    load_ir_single(4'h2);
    rti_to_shift_dr();
    shift(32, 96'h12345678, 1'b1, d);
    check("ud_capture", d[31:0], 32'hE6712945);
    exit1_to_rti();
    settle();
    check("ud_update", udo_s, 32'h12345678);
    check("ud_op_untouched", op_s, 8'h00);
    user_data_in = 32'h0BADF00D;
    rti_to_shift_dr();
    shift(32, 96'h12345678, 1'b1, d);
    check("ud_recapture", d[31:0], 32'h0BADF00D);
    exit1_to_rti();

    // USEROP update and one-cycle ready
    load_ir_single(4'h3);
    rti_to_shift_dr();
    shift(8, 96'h5A, 1'b1, d);
    check("op_capture_zero", d[7:0], 8'h00);
    exit1_to_rti();
    settle();
    check("op_5a", op_s, 8'h5A);
    check("op_ready_hi", ready_s, 1'b1);
    settle();
    check("op_ready_lo", ready_s, 1'b0);
    check("op_hold", op_s, 8'h5A);

    // Pause-DR detour mid-shift
    rti_to_shift_dr();
    shift(4, 96'h5, 1'b1, d);
    bit_step(1'b0, 1'b0, o);
    bit_step(1'b0, 1'b0, o);
    check("tdo_pause", o, 1'b0);
    bit_step(1'b1, 1'b0, o);
    bit_step(1'b0, 1'b0, o);
    shift(4, 96'hA, 1'b1, d);
    exit1_to_rti();
    settle();
    check("op_pause_a5", op_s, 8'hA5);
    check("op_pause_ready", ready_s, 1'b1);
    check("ud_hold", udo_s, 32'h12345678);

    // Five tms=1 clocks from Shift-DR reach TLR and restore IDCODE
    load_ir_single(4'hF);
    rti_to_shift_dr();
    shift(3, 96'h0, 1'b0, d);
    for (int i = 0; i < 5; i++) move(1'b1);
    move(1'b0);
    rti_to_shift_dr();
    shift(32, 96'h0, 1'b1, d);
    check("tlr_idcode", d[31:0], 32'h53817905);
    exit1_to_rti();
    settle();
    check("tlr_udo_kept", udo_s, 32'h12345678);
    check("tlr_op_kept", op_s, 8'hA5);

    // trst mid-shift clears outputs and aborts the update
    load_ir_single(4'h2);
    rti_to_shift_dr();
    shift(12, 96'hFFF, 1'b0, d);
    settle();
    check("tdo_pre_trst", tdo_s, 1'b1);
    trst = 1'b0;
    #2;
    check("trst_tdo", tdo_s, 1'b0);
    check("trst_udo", udo_s, 32'h0);
    check("trst_op", op_s, 8'h0);
    check("trst_ready", ready_s, 1'b0);
    #1;
    trst = 1'b1;
    tms  = 1'b1;
    for (int i = 0; i < 4; i++) move(1'b1);
    check("post_trst_udo", udo_s, 32'h0);
    check("post_trst_op", op_s, 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
